// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state type and parameter helpers for the button debouncer
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } db_state_t;

    function automatic int hold_width(input int long_ticks);
        return (long_ticks < 1) ? 1 : $clog2(long_ticks + 1);
    endfunction

    function automatic bit params_ok(input int n_ch, input int tick_div, input int stable_ticks,
                                     input int long_ticks, input int active_low);
        return (n_ch >= 1) && (n_ch <= 32) && (tick_div >= 2) &&
               (stable_ticks >= 2) && (stable_ticks <= 255) && (long_ticks >= 0) &&
               ((active_low == 0) || (active_low == 1));
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: synchroniser, acceptance FSM, run and hold counters
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 0,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CNT_W  = $clog2(STABLE_TICKS);
    localparam int HOLD_W = hold_width(LONG_TICKS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
    localparam logic REL_LVL = (ACTIVE_LOW != 0);
    localparam bit   LONG_EN = (LONG_TICKS != 0);

    logic [1:0]        sync_q;
    logic              s;
    db_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    // Synchroniser idles at the released level so a button held through reset stays quiet.
    assign s = sync_q[1] ^ REL_LVL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= {2{REL_LVL}};
            state_q   <= RELEASED;
            cnt_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        if (tick_i) begin
            case (state_q)
                RELEASED: begin
                    if (s) begin
                        state_d = PRESS_CHK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                PRESS_CHK: begin
                    if (!s) begin
                        state_d = RELEASED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = REL_CHK;
                        cnt_d   = CNT_W'(1);
                    end else if (LONG_EN && (hold_q != HOLD_MAX)) begin
                        hold_d = hold_q + 1'b1;
                        long_d = ((hold_q + 1'b1) == HOLD_MAX);
                    end
                end
                REL_CHK: begin
                    // hold is left alone so a release bounce cannot re-arm long_o
                    if (s) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = RELEASED;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end
    end

    assign state_o   = (state_q == PRESSED) || (state_q == REL_CHK);
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/button_debouncer_multi.sv
// rtl/button_debouncer_multi.sv - multi-channel button debouncer with shared sample prescaler
module button_debouncer_multi
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 16,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 0,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] state_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic            tick_o
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    if (!params_ok(N_CH, TICK_DIV, STABLE_TICKS, LONG_TICKS, ACTIVE_LOW)) begin : g_param_check
        $error("button_debouncer_multi: parameter out of range");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = tick;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick),
            .btn_i     (btn_i[i]),
            .state_o   (state_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i]),
            .long_o    (long_o[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// tb/tb_button_debouncer_multi.sv - directed self-checking bench for button_debouncer_multi
module tb_button_debouncer_multi;

    localparam int N_CH         = 2;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int LONG_TICKS   = 8;
    localparam int ACTIVE_LOW   = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] btn_i = 2'b11;
    logic [N_CH-1:0] state_o, press_o, release_o, long_o;
    logic            tick_o;

    always #5 clk = ~clk;

    button_debouncer_multi #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
        .LONG_TICKS(LONG_TICKS), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk), .rst(rst), .btn_i(btn_i), .state_o(state_o), .press_o(press_o),
        .release_o(release_o), .long_o(long_o), .tick_o(tick_o)
    );

    int errors = 0;
    int checks = 0;
    int step_no;
    int press_cnt [N_CH];
    int rel_cnt   [N_CH];
    int long_cnt  [N_CH];
    int first_press [N_CH];
    int first_long  [N_CH];
    int ticks;
    int both_press;
    int coinc_err;
    int watch_err;
    bit watch_en = 1'b0;
    logic watch_val = 1'b0;
    logic [N_CH-1:0] prev_state = '0;
    int rst_step;

    task automatic clear_stats();
        step_no = 0;
        ticks = 0;
        both_press = 0;
        coinc_err = 0;
        watch_err = 0;
        for (int i = 0; i < N_CH; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i] = 0;
            long_cnt[i] = 0;
            first_press[i] = -1;
            first_long[i] = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        step_no++;
        if (tick_o) ticks++;
        if (press_o == 2'b11) both_press++;
        for (int i = 0; i < N_CH; i++) begin
            if (press_o[i]) begin
                press_cnt[i]++;
                if (first_press[i] < 0) first_press[i] = step_no;
                if (!(state_o[i] && !prev_state[i])) coinc_err++;
            end
            if (release_o[i]) begin
                rel_cnt[i]++;
                if (!(!state_o[i] && prev_state[i])) coinc_err++;
            end
            if (long_o[i]) begin
                long_cnt[i]++;
                if (first_long[i] < 0) first_long[i] = step_no;
            end
        end
        if (watch_en && (state_o[0] !== watch_val)) watch_err++;
        prev_state = state_o;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    initial begin
        clear_stats();

        // reset state
        run(3);
        check("rst_state", int'(state_o), 0);
        check("rst_press", int'(press_o), 0);
        check("rst_release", int'(release_o), 0);
        check("rst_long", int'(long_o), 0);
        check("rst_tick", int'(tick_o), 0);
        rst = 1'b0;
        clear_stats();
        run(40);
        check("tick_count_40clk", ticks, 10);

        // clean press on ch0
        clear_stats();
        btn_i[0] = 1'b0;
        run(60);
        check("clean_press_cnt0", press_cnt[0], 1);
        check_range("clean_press_latency", first_press[0], 10, 15);
        check("clean_state", int'(state_o), 1);
        check("clean_ch1_press", press_cnt[1], 0);
        check("clean_release_cnt0", rel_cnt[0], 0);
        btn_i[0] = 1'b1;
        run(40);
        check("clean_release_after", rel_cnt[0], 1);
        check("clean_coincidence", coinc_err, 0);

        // bounce on press and on release
        clear_stats();
        watch_en = 1'b1;
        watch_val = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_i[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            run(3);
        end
        watch_en = 1'b0;
        btn_i[0] = 1'b0;
        run(40);
        check("bounce_state_pressed", int'(state_o[0]), 1);
        watch_en = 1'b1;
        watch_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn_i[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            run(3);
        end
        watch_en = 1'b0;
        btn_i[0] = 1'b1;
        run(40);
        check("bounce_press_cnt", press_cnt[0], 1);
        check("bounce_release_cnt", rel_cnt[0], 1);
        check("bounce_state_stable", watch_err, 0);
        check("bounce_coincidence", coinc_err, 0);

        // glitch shorter than acceptance window
        clear_stats();
        watch_en = 1'b1;
        watch_val = 1'b0;
        btn_i[0] = 1'b0;
        run(5);
        btn_i[0] = 1'b1;
        run(30);
        watch_en = 1'b0;
        check("glitch_press_cnt", press_cnt[0], 0);
        check("glitch_release_cnt", rel_cnt[0], 0);
        check("glitch_state", watch_err, 0);

        // long press
        clear_stats();
        btn_i[0] = 1'b0;
        run(80);
        check("long_press_cnt", press_cnt[0], 1);
        check("long_cnt_held", long_cnt[0], 1);
        check("long_delay", first_long[0] - first_press[0], 32);
        btn_i[0] = 1'b1;
        run(30);
        check("long_release_cnt", rel_cnt[0], 1);
        check("long_no_refire", long_cnt[0], 1);

        // both channels together
        clear_stats();
        btn_i = 2'b00;
        run(20);
        check("sim_both_same_clk", both_press, 1);
        check("sim_press_cnt1", press_cnt[1], 1);
        check("sim_state", int'(state_o), 3);
        btn_i = 2'b11;
        run(20);
        check("sim_release_cnt1", rel_cnt[1], 1);

        // reset while ch0 is pressed
        btn_i[0] = 1'b0;
        run(20);
        check("rstmid_pre_state", int'(state_o[0]), 1);
        clear_stats();
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_state", int'(state_o), 0);
        check("rstmid_pulses", int'(press_o | release_o | long_o), 0);
        run(2);
        rst = 1'b0;
        rst_step = step_no;
        run(20);
        check("rstmid_no_release", rel_cnt[0], 0);
        check("rstmid_repress_cnt", press_cnt[0], 1);
        check_range("rstmid_repress_latency", first_press[0] - rst_step, 1, 15);
        btn_i[0] = 1'b1;
        run(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer_multi.md
# button_debouncer_multi

Parametrised multi-channel debouncer for raw mechanical push-buttons and switches on the board I/O. Each channel is synchronised to the system clock, sampled on a shared slow tick, and accepted only after a programmable number of consecutive agreeing samples. It drives a clean level plus single-cycle press, release and long-press pulses that feed the button FSM and front-panel control logic.

## Interface
- `N_CH`, 4: number of independent button channels, 1..32.
- `TICK_DIV`, 16: system clocks per sample tick, >= 2.
- `STABLE_TICKS`, 4: consecutive agreeing samples needed to change debounced state, 2..255.
- `LONG_TICKS`, 0: ticks a press must be held, after acceptance, to fire `long_o`; 0 disables long-press detection.
- `ACTIVE_LOW`, 1: 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".

Ports (clk first, then reset):
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_i` in N_CH: raw asynchronous button inputs.
- `state_o` out N_CH: debounced level, 1 means pressed.
- `press_o` out N_CH: one-clk pulse when `state_o` bit rises.
- `release_o` out N_CH: one-clk pulse when `state_o` bit falls.
- `long_o` out N_CH: one-clk pulse, at most once per press.
- `tick_o` out 1: prescaler tick, one clk wide; for observation only.

## Operation
- **Synchroniser.** Two-flop synchroniser per channel, clocked every clk and not tick-gated. Its output is XORed with `ACTIVE_LOW` to give `s`, where 1 means pressed.
- **Prescaler.**
  - Counter runs 0..TICK_DIV-1 and wraps.
  - `tick` is high for the single clk in which count == TICK_DIV-1.
- **Per-channel FSM.** States are RELEASED, PRESS_CHK, PRESSED and REL_CHK. Each channel has a run counter `cnt` and a hold counter `hold`. Transitions are evaluated only on `tick`:
  - RELEASED: s=1 -> PRESS_CHK, cnt=1. Otherwise stay.
  - PRESS_CHK:
    - s=0 -> RELEASED.
    - s=1 and cnt==STABLE_TICKS-1 -> PRESSED; pulse `press_o`; hold=0.
    - s=1 otherwise -> cnt+1.
  - PRESSED:
    - s=0 -> REL_CHK, cnt=1.
    - Otherwise hold increments, saturating at LONG_TICKS.
    - When `hold` reaches LONG_TICKS (LONG_TICKS != 0): pulse `long_o` once.
  - REL_CHK:
    - s=1 -> PRESSED. `hold` keeps its value, so a bounce on release cannot re-fire `long_o`.
    - s=0 and cnt==STABLE_TICKS-1 -> RELEASED; pulse `release_o`.
    - s=0 otherwise -> cnt+1.
- **state_o** is 1 in PRESSED and REL_CHK, 0 in RELEASED and PRESS_CHK.
- **Widths.**
  - `cnt` is $clog2(STABLE_TICKS) bits.
  - `hold` is $clog2(LONG_TICKS+1) bits, minimum 1.
  - Counters never wrap.
- **Channel independence.** Channels are fully independent. Simultaneous events on several channels produce pulses in the same clk.

## Timing
- **Reset values.**
  - All outputs are 0.
  - All FSMs are RELEASED; prescaler, cnt and hold are 0.
  - Synchroniser flops reset to the released level (1 when ACTIVE_LOW=1), so a button held through reset produces no spurious pulse at deassertion.
- **Pulse registration.**
  - `press_o`, `release_o` and `long_o` are registered and asserted in the clk after the deciding tick.
  - Each is exactly one clk wide.
  - `press_o` is coincident with the rise of `state_o`; `release_o` with its fall.
- **Press latency.** From a clean input edge to `press_o` is at least (STABLE_TICKS-1)*TICK_DIV+2 clk and at most STABLE_TICKS*TICK_DIV+3 clk.
- **Glitch rejection.** A glitch of fewer than STABLE_TICKS-1 full tick periods never changes `state_o`.
- **Long-press timing.** `long_o` fires LONG_TICKS ticks after `press_o`, at the corresponding tick boundary.
- **Reset mid-operation.**
  - Immediate asynchronous clear.
  - No `release_o` is generated.
  - A button still held after reset deassertion is re-detected through the normal PRESS_CHK path.

## Structure
- **Package `debounce_pkg`.** Holds the `db_state_t` enum (RELEASED, PRESS_CHK, PRESSED, REL_CHK) and a parameter-check function that validates ranges in an elaboration-time assertion.
- **Sub-module `debounce_channel`.** One instance per channel via generate, containing the synchroniser, FSM, cnt and hold. The prescaler stays in the top level and fans `tick` out to all channels.

## Test plan
Bench configuration: N_CH=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, ACTIVE_LOW=1.

- **Clean press.** Ch0 driven low and held 60 clk, ch1 held high -> exactly one `press_o[0]` within 10..15 clk of the edge; `state_o`=2'b01; no activity on ch1.
- **Bounce.** Ch0 toggled every 3 clk for 30 clk, then stable low for 40 clk, then released with the same bounce -> exactly one `press_o[0]` and one `release_o[0]`; `state_o[0]` never toggles during the bounce.
- **Glitch.** Ch0 low for 5 clk only -> no pulses; `state_o[0]` stays 0.
- **Long press.** Ch0 held low 80 clk -> `press_o[0]`, then a single `long_o[0]` 32 clk (8 ticks) later. On release: one `release_o[0]` and no second `long_o`.
- **Simultaneous channels.** Both channels pressed in the same clk -> `press_o`=2'b11 in one clk.
- **Reset mid-press.** `rst` pulsed while ch0 is PRESSED -> outputs 0 at once and no `release_o`. With ch0 still held, `press_o[0]` re-fires within 15 clk of `rst` falling.
